mem_sched: RTL and testbench

- Sequential scheduler that shares the single byte-wide RAM/IO port between instruction fetch (IF) and the MEM stage.
- Arbitrates between the two requesters and serialises 1/2/4-byte transfers into byte accesses.
- Reads are pipelined: one address issued per cycle, data captured one cycle later.
- Assembles or splits little-endian words and returns a one-cycle done pulse. Sits between If/mem and the top-level mem_* pins.

---
 rtl/mem_sched_pkg.sv | 39 +++
 rtl/sched_rr_arb.sv | 21 ++
 rtl/mem_sched.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_sched.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// mem_sched_pkg: shared types for the byte-serial memory scheduler.
//   state_e - scheduler FSM states
//   size_e  - MEM transfer size codes (3 behaves as a word)
//   owner_e - which requester owns the current transaction
//   size_len() - byte count for a MEM size code
package mem_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SizeByte    = 2'd0,
    SizeHalf    = 2'd1,
    SizeWord    = 2'd2,
    SizeIllegal = 2'd3
  } size_e;

  typedef enum logic {
    OwnIf  = 1'b0,
    OwnMem = 1'b1
  } owner_e;

  // Instruction fetches are always a full word.
  localparam logic [2:0] IfLen = 3'd4;

  // Byte count of a MEM transfer; the illegal code falls through to a word.
  function automatic logic [2:0] size_len(input logic [1:0] size);
    case (size_e'(size))
      SizeByte: return 3'd1;
      SizeHalf: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/sched_rr_arb.sv
// sched_rr_arb: two-way round-robin arbiter.
//   req[0]   - IF request, req[1] - MEM request
//   last_gnt - owner granted most recently
//   gnt      - one-hot grant (bit 0 IF, bit 1 MEM), zero when nothing pending
module sched_rr_arb
  import mem_sched_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // On contention the side that was not served last wins.
    if (req == 2'b11) begin
      gnt = (last_gnt == OwnIf) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_sched.sv
// mem_sched: shares one byte-wide RAM/IO port between instruction fetch (IF)
// and the MEM stage. Grants one requester, serialises its 1/2/4-byte transfer
// into byte accesses (little-endian), and pulses the owner's done for a cycle.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   rdy             - low freezes the scheduler and blocks RAM writes
//   if_req/if_addr  - word fetch request (level) and byte address
//   if_flush        - abandons an IF fetch in flight
//   if_done/if_data - fetch completion pulse and instruction word
//   mem_req/mem_we/mem_size/mem_addr/mem_wdata - MEM load/store request
//   mem_done/mem_rdata - MEM completion pulse and zero-filled load data
//   ram_din         - RAM read data, one cycle after its address
//   ram_dout/ram_a/ram_wr - RAM write data, address, write strobe
//   busy            - scheduler is not idle
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic              busy
);

  // Control state
  state_e            state, state_n;
  logic [2:0]        cnt, cnt_n;
  owner_e            last_gnt, last_gnt_n;

  // Transaction context latched at grant
  owner_e            owner, owner_n;
  logic [ADDR_W-1:0] base, base_n;
  logic [2:0]        len, len_n;
  logic [31:0]       wdata, wdata_n;
  logic [31:0]       cap, cap_n;

  // Registered outputs
  logic [ADDR_W-1:0] ram_a_q, ram_a_n;
  logic [7:0]        ram_dout_q, ram_dout_n;
  logic              wr_q, wr_n;
  logic              if_done_q, if_done_n;
  logic              mem_done_q, mem_done_n;
  logic [31:0]       if_data_q, if_data_n;
  logic [31:0]       mem_rdata_q, mem_rdata_n;
  logic              busy_q, busy_n;

  logic [1:0]        req, gnt;
  logic [2:0]        cnt_inc;
  logic [1:0]        cap_idx;

  // A flushed IF request is never granted in the same cycle.
  assign req = {mem_req, if_req & ~if_flush};

  sched_rr_arb u_arb (
    .req      (req),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

  assign cnt_inc = cnt + 3'd1;
  // Byte landing this cycle is the one addressed last cycle (cnt-1); cnt=4 wraps to 3.
  assign cap_idx = cnt[1:0] - 2'd1;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    last_gnt_n  = last_gnt;
    owner_n     = owner;
    base_n      = base;
    len_n       = len;
    wdata_n     = wdata;
    cap_n       = cap;
    ram_a_n     = ram_a_q;
    ram_dout_n  = ram_dout_q;
    wr_n        = 1'b0;
    if_done_n   = 1'b0;
    mem_done_n  = 1'b0;
    if_data_n   = if_data_q;
    mem_rdata_n = mem_rdata_q;

    case (state)
      IDLE: begin
        if (gnt != 2'b00) begin
          cnt_n = 3'd0;
          cap_n = '0;
          if (gnt[1]) begin
            owner_n = OwnMem;
            base_n  = mem_addr;
            len_n   = size_len(mem_size);
            wdata_n = mem_wdata;
            state_n = mem_we ? WRITE : READ;
          end else begin
            owner_n = OwnIf;
            base_n  = if_addr;
            len_n   = IfLen;
            state_n = READ;
          end
          last_gnt_n = owner_n;
          // First byte goes out in the cycle right after the grant.
          ram_a_n    = base_n;
          if (gnt[1] && mem_we) begin
            wr_n       = 1'b1;
            ram_dout_n = mem_wdata[7:0];
          end
        end
      end

      READ: begin
        if (owner == OwnIf && if_flush) begin
          state_n = IDLE;
          cnt_n   = 3'd0;
        end else begin
          cnt_n = cnt_inc;
          if (cnt != 3'd0) begin
            cap_n[{cap_idx, 3'b000} +: 8] = ram_din;
          end
          if (cnt_inc < len) begin
            ram_a_n = base + ADDR_W'(cnt_inc);
          end
          if (cnt == len) begin
            state_n = DONE;
            cnt_n   = 3'd0;
            if (owner == OwnIf) begin
              if_done_n = 1'b1;
              if_data_n = cap_n;
            end else begin
              mem_done_n  = 1'b1;
              mem_rdata_n = cap_n;
            end
          end
        end
      end

      WRITE: begin
        cnt_n = cnt_inc;
        if (cnt_inc < len) begin
          wr_n       = 1'b1;
          ram_a_n    = base + ADDR_W'(cnt_inc);
          ram_dout_n = wdata[{cnt_inc[1:0], 3'b000} +: 8];
        end else begin
          state_n    = DONE;
          cnt_n      = 3'd0;
          mem_done_n = 1'b1;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // Control and output registers: reset, then advance only while rdy is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      last_gnt    <= OwnIf;
      ram_a_q     <= '0;
      ram_dout_q  <= 8'h00;
      wr_q        <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
      busy_q      <= 1'b0;
    end else if (rdy) begin
      state       <= state_n;
      cnt         <= cnt_n;
      last_gnt    <= last_gnt_n;
      ram_a_q     <= ram_a_n;
      ram_dout_q  <= ram_dout_n;
      wr_q        <= wr_n;
      if_done_q   <= if_done_n;
      mem_done_q  <= mem_done_n;
      if_data_q   <= if_data_n;
      mem_rdata_q <= mem_rdata_n;
      busy_q      <= busy_n;
    end
  end

  // Transaction context: only meaningful while state != IDLE, so no reset.
  always_ff @(posedge clk) begin
    if (rdy) begin
      owner <= owner_n;
      base  <= base_n;
      len   <= len_n;
      wdata <= wdata_n;
      cap   <= cap_n;
    end
  end

  // A paused cycle must not write; the held strobe re-issues the byte on resume.
  assign ram_wr    = wr_q & rdy;
  assign if_done   = if_done_q & ~if_flush;
  assign mem_done  = mem_done_q;
  assign if_data   = if_data_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_sched.sv
// tb_mem_sched: directed bench for mem_sched. A 4 KiB byte RAM model (indexed
// by ram_a[11:0]) answers reads one cycle after the address; like the rest of
// the system it is frozen while rdy is low.
module tb_mem_sched;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_data;
  logic        mem_req, mem_we, mem_done;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  ram_din, ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr, busy;

  logic [7:0]  ram [0:4095];
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  mem_sched #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a),
    .ram_wr(ram_wr), .busy(busy)
  );

  always @(posedge clk) begin
    if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
    if (rdy) ram_din <= ram[ram_a[11:0]];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; if_flush = 1'b0; rdy = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({if_done, mem_done, ram_wr, busy, ram_dout, ram_a, if_data, mem_rdata} !== '0)
      $display("FAIL reset_outs got if_done=%b mem_done=%b wr=%b busy=%b a=%h dout=%h want all 0",
               if_done, mem_done, ram_wr, busy, ram_a, ram_dout);
    else passed++;
  endtask

  task automatic test_fetch();
    int early = 0;
    if_addr = 32'h100; if_req = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        total++;
        if (ram_a !== 32'h100 + c - 1 || ram_wr !== 1'b0)
          $display("FAIL fetch_addr c=%0d got a=%h wr=%b want a=%h wr=0", c, ram_a, ram_wr, 32'h100 + c - 1);
        else passed++;
      end
      if (c < 6 && if_done) early++;
      if (c == 6) begin
        total++;
        if (if_done !== 1'b1 || if_data !== 32'h00100513)
          $display("FAIL fetch_done got done=%b data=%h want 1 00100513", if_done, if_data);
        else passed++;
        if_req = 1'b0;
      end
      if (c == 7) begin
        total++;
        if (busy !== 1'b0 || if_done !== 1'b0 || if_data !== 32'h00100513)
          $display("FAIL fetch_idle got busy=%b done=%b data=%h want 0 0 00100513", busy, if_done, if_data);
        else passed++;
      end
    end
    total++;
    if (early !== 0) $display("FAIL fetch_early_done got %0d early pulses want 0", early);
    else passed++;
  endtask

  task automatic test_half_store();
    mem_addr = 32'h200; mem_we = 1'b1; mem_size = 2'd1; mem_wdata = 32'hAABBCCDD; mem_req = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c <= 2) begin
        total++;
        if (ram_wr !== 1'b1 || ram_a !== 32'h200 + c - 1 || ram_dout !== (c == 1 ? 8'hDD : 8'hCC) || mem_done !== 1'b0)
          $display("FAIL hstore_byte c=%0d got wr=%b a=%h dout=%h done=%b", c, ram_wr, ram_a, ram_dout, mem_done);
        else passed++;
      end else begin
        total++;
        if (mem_done !== 1'b1 || ram_wr !== 1'b0)
          $display("FAIL hstore_done got done=%b wr=%b want 1 0", mem_done, ram_wr);
        else passed++;
        mem_req = 1'b0;
      end
    end
    total++;
    if ({ram[12'h202], ram[12'h201], ram[12'h200]} !== 24'h5ACCDD)
      $display("FAIL hstore_mem got %h%h%h want 5accdd", ram[12'h202], ram[12'h201], ram[12'h200]);
    else passed++;
    // Read the half back: zero-filled above 16 bits.
    @(negedge clk);
    mem_we = 1'b0; mem_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 4) begin
        total++;
        if (mem_done !== 1'b1 || mem_rdata !== 32'h0000CCDD)
          $display("FAIL hload got done=%b data=%h want 1 0000ccdd", mem_done, mem_rdata);
        else passed++;
        mem_req = 1'b0;
      end
    end
  endtask

  task automatic test_arb();
    do_reset();
    if_addr = 32'h100; if_req = 1'b1;
    mem_addr = 32'h30000; mem_we = 1'b0; mem_size = 2'd0; mem_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        total++;
        if (ram_a !== 32'h30000) $display("FAIL arb_mem_first got a=%h want 00030000", ram_a);
        else passed++;
      end
      if (c == 3) begin
        total++;
        if (mem_done !== 1'b1 || mem_rdata !== 32'h0000008C || if_done !== 1'b0)
          $display("FAIL arb_byte_load got done=%b data=%h if_done=%b want 1 0000008c 0", mem_done, mem_rdata, if_done);
        else passed++;
        mem_req = 1'b0;
      end
      if (c == 5) begin
        total++;
        if (ram_a !== 32'h100) $display("FAIL arb_if_next got a=%h want 00000100", ram_a);
        else passed++;
      end
      if (c == 10) begin
        total++;
        if (if_done !== 1'b1 || if_data !== 32'h00100513)
          $display("FAIL arb_if_done got done=%b data=%h want 1 00100513", if_done, if_data);
        else passed++;
        if_req = 1'b0;
      end
    end
    // Lone MEM access leaves last_gnt = MEM.
    @(negedge clk);
    mem_req = 1'b1;
    for (int c = 1; c <= 3; c++) @(negedge clk);
    mem_req = 1'b0;
    @(negedge clk);
    if_req = 1'b1; mem_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        total++;
        if (ram_a !== 32'h100) $display("FAIL arb_if_first got a=%h want 00000100", ram_a);
        else passed++;
      end
      if (c == 6) if_req = 1'b0;
      if (c == 8) begin
        total++;
        if (ram_a !== 32'h30000) $display("FAIL arb_mem_second got a=%h want 00030000", ram_a);
        else passed++;
      end
      if (c == 10) begin
        total++;
        if (mem_done !== 1'b1) $display("FAIL arb_mem_done got %b want 1", mem_done);
        else passed++;
        mem_req = 1'b0;
      end
    end
  endtask

  task automatic test_pause_read();
    int early = 0;
    @(negedge clk);
    if_addr = 32'h100; if_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c >= 3 && c <= 6) begin
        total++;
        if (ram_a !== 32'h102 || ram_wr !== 1'b0)
          $display("FAIL pause_hold c=%0d got a=%h wr=%b want 00000102 0", c, ram_a, ram_wr);
        else passed++;
      end
      if (c == 3) rdy = 1'b0;
      if (c == 6) rdy = 1'b1;
      if (c < 9 && if_done) early++;
      if (c == 9) begin
        total++;
        if (if_done !== 1'b1 || if_data !== 32'h00100513)
          $display("FAIL pause_done got done=%b data=%h want 1 00100513", if_done, if_data);
        else passed++;
        if_req = 1'b0;
      end
    end
    total++;
    if (early !== 0) $display("FAIL pause_early_done got %0d pulses want 0", early);
    else passed++;
  endtask

  task automatic test_pause_store();
    mem_addr = 32'h500; mem_we = 1'b1; mem_size = 2'd0; mem_wdata = 32'h00000077; mem_req = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    #1;
    total++;
    if (ram_wr !== 1'b0) $display("FAIL pstore_gate got wr=%b want 0", ram_wr);
    else passed++;
    @(negedge clk);
    total++;
    if (ram_wr !== 1'b0 || ram_a !== 32'h500 || ram[12'h500] !== 8'h00)
      $display("FAIL pstore_frozen got wr=%b a=%h mem=%h want 0 00000500 00", ram_wr, ram_a, ram[12'h500]);
    else passed++;
    rdy = 1'b1;
    #1;
    total++;
    if (ram_wr !== 1'b1 || ram_dout !== 8'h77) $display("FAIL pstore_reissue got wr=%b dout=%h want 1 77", ram_wr, ram_dout);
    else passed++;
    @(negedge clk);
    total++;
    if (mem_done !== 1'b1 || ram[12'h500] !== 8'h77)
      $display("FAIL pstore_done got done=%b mem=%h want 1 77", mem_done, ram[12'h500]);
    else passed++;
    mem_req = 1'b0;
  endtask

  task automatic test_flush();
    int ifd = 0;
    @(negedge clk);
    if_addr = 32'h100; if_req = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (if_done) ifd++;
      if (c == 1) begin
        mem_addr = 32'h300; mem_we = 1'b1; mem_size = 2'd2; mem_wdata = 32'h11223344; mem_req = 1'b1;
      end
      if (c == 2) begin if_flush = 1'b1; if_req = 1'b0; end
      if (c == 3) begin
        total++;
        if (busy !== 1'b0) $display("FAIL flush_abort got busy=%b want 0", busy);
        else passed++;
        if_flush = 1'b0;
      end
      if (c >= 4 && c <= 7) begin
        total++;
        if (ram_wr !== 1'b1 || ram_a !== 32'h300 + c - 4)
          $display("FAIL flush_store c=%0d got wr=%b a=%h want 1 %h", c, ram_wr, ram_a, 32'h300 + c - 4);
        else passed++;
        if_flush = 1'b1;
      end
      if (c == 8) begin
        total++;
        if (mem_done !== 1'b1) $display("FAIL flush_store_done got %b want 1", mem_done);
        else passed++;
        mem_req = 1'b0; if_flush = 1'b0;
      end
      if (c == 9) begin if_req = 1'b1; if_flush = 1'b1; end
      if (c == 10) begin
        total++;
        if (busy !== 1'b0) $display("FAIL flush_idle_block got busy=%b want 0", busy);
        else passed++;
        if_flush = 1'b0;
      end
      if (c == 11) begin
        total++;
        if (busy !== 1'b1) $display("FAIL flush_idle_release got busy=%b want 1", busy);
        else passed++;
        if_req = 1'b0;
      end
    end
    total++;
    if (ifd !== 0) $display("FAIL flush_no_if_done got %0d pulses want 0", ifd);
    else passed++;
    total++;
    if ({ram[12'h303], ram[12'h302], ram[12'h301], ram[12'h300]} !== 32'h11223344)
      $display("FAIL flush_store_mem got %h%h%h%h want 11223344", ram[12'h303], ram[12'h302], ram[12'h301], ram[12'h300]);
    else passed++;
  endtask

  task automatic test_reset_mid_and_wrap();
    int bad = 0;
    do_reset();
    mem_addr = 32'h400; mem_we = 1'b1; mem_size = 2'd2; mem_wdata = 32'hDEADBEEF; mem_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 2) begin
        total++;
        if (ram_wr !== 1'b1 || ram_a !== 32'h401 || ram_dout !== 8'hBE)
          $display("FAIL rstmid_pre got wr=%b a=%h dout=%h want 1 00000401 be", ram_wr, ram_a, ram_dout);
        else passed++;
        rst = 1'b1; mem_req = 1'b0;
      end
      if (c == 3) begin
        total++;
        if ({if_done, mem_done, ram_wr, busy, ram_dout, ram_a, if_data, mem_rdata} !== '0)
          $display("FAIL rstmid_outs got wr=%b busy=%b a=%h dout=%h done=%b want all 0", ram_wr, busy, ram_a, ram_dout, mem_done);
        else passed++;
        rst = 1'b0;
      end
      if (c >= 4 && (mem_done || ram_wr)) bad++;
    end
    total++;
    if (bad !== 0 || ram[12'h402] !== 8'h00 || ram[12'h401] !== 8'hBE)
      $display("FAIL rstmid_after got bad=%0d m401=%h m402=%h want 0 be 00", bad, ram[12'h401], ram[12'h402]);
    else passed++;
    // Wrap-around word load through the illegal size code.
    mem_addr = 32'hFFFFFFFE; mem_we = 1'b0; mem_size = 2'd3; mem_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        total++;
        if (ram_a !== 32'hFFFFFFFE + c - 1)
          $display("FAIL wrap_addr c=%0d got %h want %h", c, ram_a, 32'hFFFFFFFE + c - 1);
        else passed++;
      end
      if (c == 6) begin
        total++;
        if (mem_done !== 1'b1 || mem_rdata !== 32'hD48CB2A1)
          $display("FAIL wrap_data got done=%b data=%h want 1 d48cb2a1", mem_done, mem_rdata);
        else passed++;
        mem_req = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
    ram[12'h100] <= 8'h13; ram[12'h101] <= 8'h05; ram[12'h102] <= 8'h10; ram[12'h103] <= 8'h00;
    ram[12'h202] <= 8'h5A;
    ram[12'h000] <= 8'h8C; ram[12'h001] <= 8'hD4;
    ram[12'hFFE] <= 8'hA1; ram[12'hFFF] <= 8'hB2;
    rst = 1'b1; rdy = 1'b1; if_req = 1'b0; if_flush = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h0; mem_wdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_fetch();
    test_half_store();
    test_arb();
    test_pause_read();
    test_pause_store();
    test_flush();
    test_reset_mid_and_wrap();
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
